// File: rtl/conv1_maxpool_pkg.sv
// Shared constants and FSM encoding for the conv1 pooling stage.
package conv1_pkg;
  localparam int PIX_W         = 8;
  localparam int CONV1_CH      = 4;
  localparam int CONV1_OUT_PIX = 24;
  localparam int POOL1_OUT_PIX = 12;

  typedef enum logic {
    EVEN = 1'b0,
    ODD  = 1'b1
  } pool_state_t;
endpackage

// File: rtl/conv1_maxpool_pool2x2.sv
// Combinational 2x2 window reduce: max by default, average when CONV1_POOL_AVG_EN is defined.
module pool2x2_unit #(
  parameter int PIX_W = 8
) (
  input  logic [PIX_W-1:0] a,
  input  logic [PIX_W-1:0] b,
  input  logic [PIX_W-1:0] c,
  input  logic [PIX_W-1:0] d,
  output logic [PIX_W-1:0] y
);

`ifdef CONV1_POOL_AVG_EN
  // Two extra bits hold the four-term sum; dropping the low two divides by 4.
  logic [PIX_W+1:0] sum;
  assign sum = {2'b00, a} + {2'b00, b} + {2'b00, c} + {2'b00, d};
  assign y   = sum[PIX_W+1:2];
`else
  logic [PIX_W-1:0] max_ab;
  logic [PIX_W-1:0] max_cd;
  assign max_ab = (a > b) ? a : b;
  assign max_cd = (c > d) ? c : d;
  assign y      = (max_ab > max_cd) ? max_ab : max_cd;
`endif

endmodule

// File: rtl/conv1_maxpool.sv
// 2x2 stride-2 pooling after conv1: pairs input rows, emits one pooled row per pair.
// Optional average pooling via macro CONV1_POOL_AVG_EN (default: max pooling).
module conv1_maxpool #(
  parameter int PIX_W  = 8,
  parameter int IN_PIX = 24,
  parameter int ROWS   = 24
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          en,
  input  logic                          frm_sync,
  input  logic                          din_vald,
  input  logic [IN_PIX*PIX_W-1:0]       din_0,
  input  logic [IN_PIX*PIX_W-1:0]       din_1,
  input  logic [IN_PIX*PIX_W-1:0]       din_2,
  input  logic [IN_PIX*PIX_W-1:0]       din_3,
  output logic                          dout_vald,
  output logic [(IN_PIX/2)*PIX_W-1:0]   dout_0,
  output logic [(IN_PIX/2)*PIX_W-1:0]   dout_1,
  output logic [(IN_PIX/2)*PIX_W-1:0]   dout_2,
  output logic [(IN_PIX/2)*PIX_W-1:0]   dout_3,
  output logic                          frame_done
);
  import conv1_pkg::*;

  localparam int OUT_PIX = IN_PIX / 2;
  localparam int CNT_W   = $clog2(ROWS + 1);

  // Pixel i of a row sits at the MSB end, so it maps to packed index IN_PIX-1-i.
  logic [CONV1_CH-1:0][IN_PIX-1:0][PIX_W-1:0]  din_pix;
  logic [CONV1_CH-1:0][IN_PIX-1:0][PIX_W-1:0]  buf_reg;
  logic [CONV1_CH-1:0][OUT_PIX-1:0][PIX_W-1:0] pool_next;
  logic [CONV1_CH-1:0][OUT_PIX-1:0][PIX_W-1:0] dout_reg;

  pool_state_t      state_reg, state_next;
  logic [CNT_W-1:0] row_cnt_reg, row_cnt_next;
  logic             vald_reg, vald_next;
  logic             done_reg, done_next;
  logic             load_buf, load_out;
  logic             accept;

  assign din_pix[0] = din_0;
  assign din_pix[1] = din_1;
  assign din_pix[2] = din_2;
  assign din_pix[3] = din_3;

  assign accept = en && din_vald;

  genvar gi, gj;
  generate
    for (gi = 0; gi < CONV1_CH; gi++) begin : g_ch
      for (gj = 0; gj < OUT_PIX; gj++) begin : g_pix
        pool2x2_unit #(.PIX_W(PIX_W)) u_pool (
          .a (buf_reg[gi][IN_PIX-1-2*gj]),
          .b (buf_reg[gi][IN_PIX-2-2*gj]),
          .c (din_pix[gi][IN_PIX-1-2*gj]),
          .d (din_pix[gi][IN_PIX-2-2*gj]),
          .y (pool_next[gi][OUT_PIX-1-gj])
        );
      end
    end
  endgenerate

  always_comb begin
    state_next   = state_reg;
    row_cnt_next = row_cnt_reg;
    vald_next    = 1'b0;
    done_next    = 1'b0;
    load_buf     = 1'b0;
    load_out     = 1'b0;
    if (frm_sync) begin
      // A row arriving with the resync opens the new frame as its first row.
      row_cnt_next = '0;
      load_buf     = accept;
      state_next   = accept ? ODD : EVEN;
    end else if (accept) begin
      case (state_reg)
        EVEN: begin
          load_buf   = 1'b1;
          state_next = ODD;
        end
        ODD: begin
          load_out   = 1'b1;
          vald_next  = 1'b1;
          state_next = EVEN;
          if (row_cnt_reg + CNT_W'(2) == CNT_W'(ROWS)) begin
            row_cnt_next = '0;
            done_next    = 1'b1;
          end else begin
            row_cnt_next = row_cnt_reg + CNT_W'(2);
          end
        end
        default: state_next = EVEN;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= EVEN;
      row_cnt_reg <= '0;
      vald_reg    <= 1'b0;
      done_reg    <= 1'b0;
      buf_reg     <= '0;
      dout_reg    <= '0;
    end else begin
      state_reg   <= state_next;
      row_cnt_reg <= row_cnt_next;
      vald_reg    <= vald_next;
      done_reg    <= done_next;
      if (load_buf) buf_reg  <= din_pix;
      if (load_out) dout_reg <= pool_next;
    end
  end

  assign dout_vald  = vald_reg;
  assign frame_done = done_reg;
  assign dout_0     = dout_reg[0];
  assign dout_1     = dout_reg[1];
  assign dout_2     = dout_reg[2];
  assign dout_3     = dout_reg[3];

endmodule

// File: tb/tb_conv1_maxpool.sv
// Randomized self-checking bench for conv1_maxpool against a row-level reference model.
module tb_conv1_maxpool;
  logic         clk = 1'b0;
  logic         rst_n;
  logic         en, frm_sync, din_vald;
  logic [191:0] din_0, din_1, din_2, din_3;
  logic         dout_vald, frame_done;
  logic [95:0]  dout_0, dout_1, dout_2, dout_3;

  conv1_maxpool dut (
    .clk(clk), .rst_n(rst_n), .en(en), .frm_sync(frm_sync), .din_vald(din_vald),
    .din_0(din_0), .din_1(din_1), .din_2(din_2), .din_3(din_3),
    .dout_vald(dout_vald), .dout_0(dout_0), .dout_1(dout_1), .dout_2(dout_2),
    .dout_3(dout_3), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Reference model state, kept as plain pixel arrays.
  int              cur_row [4][24];
  int              m_buf   [4][24];
  bit              m_odd;
  int              m_cnt;
  logic            exp_vald, exp_done;
  logic [3:0][95:0] exp_dout;
  logic [3:0][95:0] got_dout;

  assign got_dout = {dout_3, dout_2, dout_1, dout_0};

  function automatic int pool4(input int a, input int b, input int c, input int d);
`ifdef CONV1_POOL_AVG_EN
    return (a + b + c + d) / 4;
`else
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return m;
`endif
  endfunction

  task automatic rand_row();
    for (int c = 0; c < 4; c++)
      for (int i = 0; i < 24; i++)
        cur_row[c][i] = $urandom_range(0, 255);
  endtask

  task automatic model_reset();
    m_odd    = 1'b0;
    m_cnt    = 0;
    exp_vald = 1'b0;
    exp_done = 1'b0;
    exp_dout = '0;
    for (int c = 0; c < 4; c++)
      for (int i = 0; i < 24; i++)
        m_buf[c][i] = 0;
  endtask

  // Called at a negedge: drive one cycle, advance the model, return at the next negedge.
  task automatic step(input logic e, input logic v, input logic s);
    logic [3:0][191:0] bus;
    bit acc;
    for (int c = 0; c < 4; c++)
      for (int i = 0; i < 24; i++)
        bus[c][191-8*i -: 8] = cur_row[c][i][7:0];
    din_0 = bus[0]; din_1 = bus[1]; din_2 = bus[2]; din_3 = bus[3];
    en = e; din_vald = v; frm_sync = s;
    acc = e && v;
    exp_vald = 1'b0;
    exp_done = 1'b0;
    if (s) begin
      m_cnt = 0;
      m_odd = acc;
      if (acc) m_buf = cur_row;
    end else if (acc) begin
      if (!m_odd) begin
        m_buf = cur_row;
        m_odd = 1'b1;
      end else begin
        for (int c = 0; c < 4; c++)
          for (int j = 0; j < 12; j++)
            exp_dout[c][95-8*j -: 8] = 8'(pool4(m_buf[c][2*j], m_buf[c][2*j+1],
                                                cur_row[c][2*j], cur_row[c][2*j+1]));
        exp_vald = 1'b1;
        m_cnt += 2;
        if (m_cnt == 24) begin
          exp_done = 1'b1;
          m_cnt    = 0;
        end
        m_odd = 1'b0;
      end
    end
    @(posedge clk);
    @(negedge clk);
    if (exp_vald) $display("pooled row out: model row_cnt=%0d frame_done=%b", m_cnt, exp_done);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; en = 0; din_vald = 0; frm_sync = 0;
    din_0 = '0; din_1 = '0; din_2 = '0; din_3 = '0;
    model_reset();
    @(negedge clk);
    n_vec++;
    if (dout_vald !== 1'b0 || frame_done !== 1'b0 || got_dout !== '0) begin
      n_err++;
      $display("FAIL reset_init: vald=%b done=%b dout=%h required all zero", dout_vald, frame_done, got_dout);
    end
    rst_n = 1'b1;
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      rand_row();
      step(1, 1, 0);
      n_vec++;
      if (dout_vald !== exp_vald || frame_done !== exp_done || got_dout !== exp_dout) begin
        n_err++;
        $display("FAIL reset_pre row%0d: vald=%b/%b done=%b/%b dout=%h exp=%h", k, dout_vald, exp_vald, frame_done, exp_done, got_dout, exp_dout);
      end
    end
    // Asynchronous reset in the middle of a pair.
    rst_n = 1'b0;
    #1;
    model_reset();
    n_vec++;
    if (dout_vald !== 1'b0 || frame_done !== 1'b0 || got_dout !== '0) begin
      n_err++;
      $display("FAIL reset_midpair: vald=%b done=%b dout=%h required all zero", dout_vald, frame_done, got_dout);
    end
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 2; k++) begin
      rand_row();
      step(1, 1, 0);
      n_vec++;
      if (dout_vald !== (k == 1) || got_dout !== exp_dout || frame_done !== exp_done) begin
        n_err++;
        $display("FAIL reset_post row%0d: vald=%b/%b done=%b/%b dout=%h exp=%h", k, dout_vald, exp_vald, frame_done, exp_done, got_dout, exp_dout);
      end
    end
  endtask

  task automatic test_basic_max();
    logic [7:0] px;
    rand_row();
    for (int i = 0; i < 24; i++) cur_row[0][i] = i;
    step(1, 1, 0);
    rand_row();
    for (int i = 0; i < 24; i++) cur_row[0][i] = 100 + i;
    step(1, 1, 0);
    n_vec++;
    if (dout_vald !== 1'b1 || got_dout !== exp_dout) begin
      n_err++;
      $display("FAIL basic_max: vald=%b dout=%h exp=%h", dout_vald, got_dout, exp_dout);
    end
    for (int j = 0; j < 12; j++) begin
      px = dout_0[95-8*j -: 8];
      n_vec++;
      if (px !== 8'(101 + 2*j)) begin
        n_err++;
        $display("FAIL basic_max_px%0d: got %0d required %0d", j, px, 101 + 2*j);
      end
    end
  endtask

  task automatic test_max_position();
    logic [3:0][95:0] all_f0;
    int pos;
    for (int j = 0; j < 48; j++) all_f0[j/12][95-8*(j%12) -: 8] = 8'hF0;
    for (int p = 0; p < 4; p++) begin
      int row_a [4][24];
      int row_b [4][24];
      for (int c = 0; c < 4; c++)
        for (int i = 0; i < 24; i++) begin
          row_a[c][i] = $urandom_range(0, 8'hEF);
          row_b[c][i] = $urandom_range(0, 8'hEF);
        end
      for (int c = 0; c < 4; c++) begin
        pos = (p + c) % 4;
        for (int j = 0; j < 12; j++)
          case (pos)
            0: row_a[c][2*j]   = 8'hF0;
            1: row_a[c][2*j+1] = 8'hF0;
            2: row_b[c][2*j]   = 8'hF0;
            default: row_b[c][2*j+1] = 8'hF0;
          endcase
      end
      cur_row = row_a;
      step(1, 1, 0);
      cur_row = row_b;
      step(1, 1, 0);
      n_vec++;
      if (dout_vald !== 1'b1 || got_dout !== all_f0) begin
        n_err++;
        $display("FAIL max_pos%0d: vald=%b dout=%h required all F0", p, dout_vald, got_dout);
      end
    end
  endtask

  task automatic test_frame();
    int pulses, dones, gap;
    step(1, 0, 1);
    for (int f = 0; f < 2; f++) begin
      pulses = 0;
      dones  = 0;
      for (int r = 0; r < 24; r++) begin
        gap = $urandom_range(0, 3);
        for (int g = 0; g <= gap; g++) begin
          if (g == gap) begin
            rand_row();
            step(1, 1, 0);
          end else begin
            step(1, 0, 0);
          end
          if (dout_vald === 1'b1) pulses++;
          if (frame_done === 1'b1) dones++;
          n_vec++;
          if (dout_vald !== exp_vald || frame_done !== exp_done || got_dout !== exp_dout) begin
            n_err++;
            $display("FAIL frame%0d row%0d: vald=%b/%b done=%b/%b dout=%h exp=%h", f, r, dout_vald, exp_vald, frame_done, exp_done, got_dout, exp_dout);
          end
        end
      end
      n_vec++;
      if (pulses !== 12 || dones !== 1 || frame_done !== 1'b1) begin
        n_err++;
        $display("FAIL frame%0d_count: pulses=%0d dones=%0d last_done=%b required 12/1/1", f, pulses, dones, frame_done);
      end
    end
  endtask

  task automatic test_resync_stall();
    logic req_v [6] = '{0, 0, 1, 0, 0, 1};
    logic en_v  [6] = '{1, 1, 1, 0, 1, 1};
    logic syn_v [6] = '{0, 1, 0, 0, 0, 0};
    for (int k = 0; k < 6; k++) begin
      rand_row();
      step(en_v[k], 1, syn_v[k]);
      n_vec++;
      if (dout_vald !== req_v[k] || got_dout !== exp_dout || frame_done !== exp_done) begin
        n_err++;
        $display("FAIL resync_stall step%0d: vald=%b required %b done=%b/%b dout=%h exp=%h", k, dout_vald, req_v[k], frame_done, exp_done, got_dout, exp_dout);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic e, v, s;
    for (int k = 0; k < 300; k++) begin
      rand_row();
      e = ($urandom_range(0, 3) != 0);
      v = ($urandom_range(0, 3) != 0);
      s = ($urandom_range(0, 40) == 0);
      step(e, v, s);
      n_vec++;
      if (dout_vald !== exp_vald || frame_done !== exp_done || got_dout !== exp_dout) begin
        n_err++;
        $display("FAIL random cyc%0d: vald=%b/%b done=%b/%b dout=%h exp=%h", k, dout_vald, exp_vald, frame_done, exp_done, got_dout, exp_dout);
      end
    end
  endtask

`ifdef CONV1_POOL_AVG_EN
  task automatic test_avg();
    rand_row();
    for (int j = 0; j < 12; j++) begin
      cur_row[0][2*j] = 1; cur_row[0][2*j+1] = 2;
      cur_row[1][2*j] = 255; cur_row[1][2*j+1] = 255;
    end
    step(1, 1, 0);
    rand_row();
    for (int j = 0; j < 12; j++) begin
      cur_row[0][2*j] = 3; cur_row[0][2*j+1] = 5;
      cur_row[1][2*j] = 255; cur_row[1][2*j+1] = 255;
    end
    step(1, 1, 0);
    n_vec++;
    if (dout_vald !== 1'b1 || dout_0 !== {12{8'd2}} || dout_1 !== {12{8'd255}} || got_dout !== exp_dout) begin
      n_err++;
      $display("FAIL avg: vald=%b ch0=%h ch1=%h required 02s/FFs, full=%h exp=%h", dout_vald, dout_0, dout_1, got_dout, exp_dout);
    end
  endtask
`endif

  initial begin
    test_reset();
`ifdef CONV1_POOL_AVG_EN
    test_avg();
`else
    test_basic_max();
    test_max_position();
`endif
    test_frame();
    test_resync_stall();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/conv1_maxpool.md
Name: conv1_maxpool

Overview:
- 2x2, stride-2 pooling stage placed directly downstream of the first convolution layer.
- Consumes one activated output row per valid cycle: 4 channels x 24 pixels x 8 bits.
- Pairs consecutive rows and emits one pooled row per pair: 4 channels x 12 pixels x 8 bits.
- Tracks row parity and frame position, and flags the last pooled row of each frame for the next layer.

Parameters:
- PIX_W, 8, pixel width in bits; pixels are unsigned post-activation values.
- IN_PIX, 24, pixels per input row per channel (must be even).
- ROWS, 24, input rows per frame (must be even); output rows per frame = ROWS/2.

Ports:
- clk  input  1  clock.
- rst_n  input  1  reset, asynchronous, active-low.
- en  input  1  stage enable; when low, no input row is captured.
- frm_sync  input  1  start-of-frame resync; clears row parity and row count.
- din_vald  input  1  input row valid.
- din_0..din_3  input  IN_PIX*PIX_W (192) each  channel 0..3 row; pixel i at [191-8i -: 8].
- dout_vald  output  1  pooled row valid, single-cycle pulse.
- dout_0..dout_3  output  (IN_PIX/2)*PIX_W (96) each  pooled row; pixel j at [95-8j -: 8].
- frame_done  output  1  pulses together with the dout_vald of the last pooled row in a frame.

Behaviour:
- Reset: dout_0..3 = 0, dout_vald = 0, frame_done = 0, row buffer = 0, state = EVEN, row_cnt = 0.
- Reset is effective at any time, including mid-pair or mid-frame; the partial pair is discarded.
- Accept condition: a row is accepted when en && din_vald.
- State EVEN, row accepted:
  - all four channel rows are latched into the row buffer;
  - state moves to ODD;
  - no output is produced.
- State ODD, row accepted:
  - each output pixel is computed for every channel c and every j in 0..IN_PIX/2-1:
    dout_c[j] = max(buf_c[2j], buf_c[2j+1], din_c[2j], din_c[2j+1]);
  - outputs are registered, so dout_vald goes high for exactly 1 cycle on the edge after the ODD-row capture (latency 1);
  - state returns to EVEN; row_cnt increments by 2.
- End of frame: if row_cnt reaches ROWS on the ODD capture, frame_done pulses in the same cycle as that dout_vald, and row_cnt wraps to 0.
- dout_0..3 hold their last value between pulses. dout_vald and frame_done are 0 on every cycle with no new result.
- en low:
  - rows are not captured; state, row_cnt and the row buffer are frozen;
  - a pending dout_vald still deasserts after its single cycle.
- Gaps of any length between accepted rows are allowed; parity is preserved across gaps.
- frm_sync high: state = EVEN and row_cnt = 0 on the next edge.
- frm_sync with an accepted row in the same cycle: that row is taken as the EVEN (first) row of the new frame, so it is latched and no output is produced.
- Arithmetic: compare-only; output width equals input width; no overflow is possible.

Optional Feature:
- Macro: CONV1_POOL_AVG_EN.
- Defined: average pooling. dout = (a+b+c+d) >> 2, using a 10-bit sum truncated to 8 bits. Latency and handshake are unchanged.
- Undefined: max pooling as specified above.

Decomposition:
- Shared package conv1_pkg:
  - PIX_W = 8, CONV1_CH = 4, CONV1_OUT_PIX = 24, POOL1_OUT_PIX = 12;
  - state encoding EVEN = 0, ODD = 1.
- Sub-module pool2x2_unit:
  - combinational 4-input reduce, either max or average depending on the macro;
  - instantiated 4 x 12 = 48 times via generate.

Test Plan:
- Reset check: assert rst_n=0 mid-pair, then release -> all outputs 0; the next accepted row is treated as EVEN.
- Basic max: ch0 row A pixel i = i, row B pixel i = 100+i -> one cycle after row B, dout_vald=1 and dout_0[j] = 101+2j (j=0 gives 101, j=11 gives 123).
- Max position: windows whose maximum is placed in each of the four positions in turn (e.g. 0xF0 at buf[0], buf[1], din[0], din[1]) -> dout = 0xF0 in every case; other channels independent.
- Frame: 24 rows at random gaps with en=1 -> exactly 12 dout_vald pulses; frame_done=1 only with the 12th; row_cnt back to 0.
- Resync and stall:
  - one row, then frm_sync together with a row -> no output;
  - a third row -> one output pooled from rows 2 and 3;
  - en=0 with din_vald=1 -> no capture and no pulse.
- Avg (CONV1_POOL_AVG_EN): window {1,2,3,5} -> 2; window {255,255,255,255} -> 255.
